mouse_transmitter: RTL
======================

// Module: mouse_transmitter
// PURPOSE
//  PS/2 host-to-device transmitter: sends one command byte (e.g. 0xFF reset, 0xF4 enable
//  reporting) from the FPGA host to the mouse. It is the counterpart of MouseReceiver and
//  shares the CLK_MOUSE/DATA_MOUSE lines with it. The mouse master FSM drives this block.
//  Both lines are open-drain: this block only ever drives them low or releases them.
// PARAMETERS
//  INHIBIT_CYCLES  6000    CLK cycles the mouse clock is held low before the start bit (>=100us @50MHz)
//  REQ_HOLD_CYCLES 50      CLK cycles data and clock are both held low before the clock is released
//  TIMEOUT_CYCLES  750000  max CLK cycles between mouse clock edges (15ms @50MHz) before abort
// PORTS
//  CLK              in   1  system clock
//  RESET            in   1  asynchronous, active-low reset
//  SEND_BYTE        in   1  1-cycle request; sampled only while BUSY=0
//  BYTE_TO_SEND     in   8  command byte; latched in the cycle SEND_BYTE is accepted
//  CLK_MOUSE_IN     in   1  mouse clock line (raw, asynchronous)
//  DATA_MOUSE_IN    in   1  mouse data line (raw, asynchronous)
//  CLK_MOUSE_OUT_EN out  1  1 = pull mouse clock low, 0 = release
//  DATA_MOUSE_OUT_EN out 1  1 = pull mouse data low, 0 = release
//  BUSY             out  1  high from the cycle after acceptance until the cycle BYTE_SENT pulses
//  BYTE_SENT        out  1  1-cycle pulse at the end of every transfer, including failed ones
//  BYTE_ERROR_CODE  out  2  00 ok/acked, 01 no ack, 10 timeout; valid with BYTE_SENT, held until next accept
// BEHAVIOUR
//  Reset (RESET=0, async): state IDLE; all outputs 0 (both lines released); counters cleared.
//  Inputs pass through a 2-FF synchroniser; edges are detected on the synchronised clock.
//  Frame register is 10 bits {stop=1, parity, data[7:0]}, shifted out LSB first.
//  Parity is odd: parity = ~^BYTE_TO_SEND.
//  FSM:
//   IDLE    : SEND_BYTE=1 -> latch frame, clear counters, go to INHIBIT (BUSY=1 the next cycle).
//   INHIBIT : CLK_OUT_EN=1 for INHIBIT_CYCLES cycles -> REQUEST.
//   REQUEST : CLK_OUT_EN=1 and DATA_OUT_EN=1 (start bit) for REQ_HOLD_CYCLES -> release the clock, go to SHIFT.
//   SHIFT   : on each synced falling edge of the mouse clock: DATA_OUT_EN=~frame[0], shift right, bit_cnt++.
//             After the 10th falling edge (stop bit, line released) -> WAIT_ACK.
//   WAIT_ACK: at the next falling edge, sample synced data: 0 -> code 00, 1 -> code 01; -> WAIT_IDLE.
//   WAIT_IDLE: wait until the synced clock and data are both 1 -> DONE.
//   DONE    : BYTE_SENT=1 for one cycle, BUSY=0 -> IDLE.
//  Timeout: counter runs in SHIFT/WAIT_ACK/WAIT_IDLE and clears on every synced mouse clock edge.
//   Reaching TIMEOUT_CYCLES -> release both lines, code 10, go to DONE.
//  Data changes only after a falling edge, so it is stable while the mouse clock is high (device samples there).
//  SEND_BYTE while BUSY=1: ignored; no queueing, latched byte unchanged.
//  SEND_BYTE in the DONE cycle: ignored; it is accepted only in IDLE.
//  Reset mid-frame: lines released immediately (async), FSM returns to IDLE, no BYTE_SENT pulse.
//  Mouse clock edges seen in IDLE/INHIBIT/REQUEST: ignored.
//  Latency: BUSY rises 1 cycle after SEND_BYTE; the clock line falls in the same cycle as BUSY.
// TESTING (bench params: INHIBIT_CYCLES=10, REQ_HOLD_CYCLES=4, TIMEOUT_CYCLES=2000; device model
//  clocks at 40us period, samples data on rising edges, optionally drives the ACK)
//  1 Reset held 0 with random inputs -> both OUT_EN=0, BUSY=0, BYTE_SENT=0, code 00; after release, still idle.
//  2 SEND 0xF4 with ACK -> clock low 10 cyc, start 0; model captures bits 0,0,1,0,1,1,1,1, parity 0, stop 1;
//    -> one BYTE_SENT pulse, code 00.
//  3 SEND 0xFF with ACK -> model captures eight 1s, parity 1, stop 1 -> code 00.
//  4 SEND 0x00, model leaves data high on the 11th clock -> parity 1 captured, code 01, BYTE_SENT pulse.
//  5 SEND 0xF3, model never clocks -> 2000 cycles after clock release: both lines released,
//    code 10, BYTE_SENT pulse.
//  6 Second SEND_BYTE (0xAA) mid-frame is ignored (0xF4 completes intact);
//    RESET=0 pulse mid-frame -> lines released in the same cycle, no BYTE_SENT, the next send works.

Source files
------------

// File: rtl/mouse_transmitter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : mouse_transmitter
// Purpose  : PS/2 host-to-device transmitter. Sends one command byte to the
//            mouse over open-drain clock/data lines (drive low or release).
// Revision : 1.0 - initial release
// ============================================================================
module mouse_transmitter #(
  parameter int INHIBIT_CYCLES  = 6000,
  parameter int REQ_HOLD_CYCLES = 50,
  parameter int TIMEOUT_CYCLES  = 750000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SEND_BYTE,
  input  logic [7:0] BYTE_TO_SEND,
  input  logic       CLK_MOUSE_IN,
  input  logic       DATA_MOUSE_IN,
  output logic       CLK_MOUSE_OUT_EN,
  output logic       DATA_MOUSE_OUT_EN,
  output logic       BUSY,
  output logic       BYTE_SENT,
  output logic [1:0] BYTE_ERROR_CODE
);

  // One shared counter serves the inhibit, request and timeout phases.
  localparam int MAX_A   = (INHIBIT_CYCLES > REQ_HOLD_CYCLES) ? INHIBIT_CYCLES : REQ_HOLD_CYCLES;
  localparam int MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] REQ_LAST     = CNT_W'(REQ_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQUEST   = 3'd2;
  localparam logic [2:0] ST_SHIFT     = 3'd3;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd4;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;

  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       bit_cnt;
  logic [9:0]       frame;
  logic             data_drive;
  logic [1:0]       err_code;

  logic clk_meta, clk_sync, clk_prev;
  logic data_meta, data_sync;
  logic clk_fall, clk_edge;
  logic watching, timeout;

  // Two-flop synchronisers plus one history flop for edge detection.
  // Reset to 1 (idle bus level) so release of reset creates no false edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      clk_meta  <= 1'b1;
      clk_sync  <= 1'b1;
      clk_prev  <= 1'b1;
      data_meta <= 1'b1;
      data_sync <= 1'b1;
    end else begin
      clk_meta  <= CLK_MOUSE_IN;
      clk_sync  <= clk_meta;
      clk_prev  <= clk_sync;
      data_meta <= DATA_MOUSE_IN;
      data_sync <= data_meta;
    end
  end

  assign clk_fall = clk_prev & ~clk_sync;
  assign clk_edge = clk_prev ^ clk_sync;
  assign watching = (state == ST_SHIFT) || (state == ST_WAIT_ACK) || (state == ST_WAIT_IDLE);
  // A timeout only fires when no mouse clock edge arrives in this cycle.
  assign timeout  = watching && !clk_edge && (cnt == TIMEOUT_LAST);

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:      if (SEND_BYTE) state_next = ST_INHIBIT;
      ST_INHIBIT:   if (cnt == INHIBIT_LAST) state_next = ST_REQUEST;
      ST_REQUEST:   if (cnt == REQ_LAST) state_next = ST_SHIFT;
      ST_SHIFT: begin
        if (timeout) state_next = ST_DONE;
        else if (clk_fall && (bit_cnt == 4'd9)) state_next = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        if (timeout) state_next = ST_DONE;
        else if (clk_fall) state_next = ST_WAIT_IDLE;
      end
      ST_WAIT_IDLE: begin
        if (timeout) state_next = ST_DONE;
        else if (clk_sync && data_sync) state_next = ST_WAIT_IDLE == state ? ST_DONE : state;
      end
      ST_DONE:      state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Datapath: phase counter, frame shifter, data-line drive and result code.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      cnt        <= '0;
      bit_cnt    <= 4'd0;
      frame      <= 10'd0;
      data_drive <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      if (state_next != state) begin
        cnt <= '0;
      end else if (watching && clk_edge) begin
        cnt <= '0;
      end else if (state != ST_IDLE && state != ST_DONE) begin
        cnt <= cnt + CNT_W'(1);
      end

      if (state == ST_IDLE && SEND_BYTE) begin
        frame    <= {1'b1, ~^BYTE_TO_SEND, BYTE_TO_SEND};
        bit_cnt  <= 4'd0;
        err_code <= 2'b00;
      end

      // Start bit keeps the data line low until the first falling edge.
      if (state == ST_REQUEST) begin
        data_drive <= 1'b1;
      end

      // Present the next bit right after a falling edge so it is stable
      // while the mouse clock is high.
      if (state == ST_SHIFT && clk_fall) begin
        data_drive <= ~frame[0];
        frame      <= {1'b0, frame[9:1]};
        bit_cnt    <= bit_cnt + 4'd1;
      end

      if (state == ST_WAIT_ACK && clk_fall) begin
        err_code <= data_sync ? 2'b01 : 2'b00;
      end

      if (timeout) begin
        err_code <= 2'b10;
      end
    end
  end

  // Output decode from the current state.
  always_comb begin
    CLK_MOUSE_OUT_EN  = 1'b0;
    DATA_MOUSE_OUT_EN = 1'b0;
    BUSY              = 1'b0;
    BYTE_SENT         = 1'b0;
    case (state)
      ST_INHIBIT: begin
        CLK_MOUSE_OUT_EN = 1'b1;
        BUSY             = 1'b1;
      end
      ST_REQUEST: begin
        CLK_MOUSE_OUT_EN  = 1'b1;
        DATA_MOUSE_OUT_EN = 1'b1;
        BUSY              = 1'b1;
      end
      ST_SHIFT: begin
        DATA_MOUSE_OUT_EN = data_drive;
        BUSY              = 1'b1;
      end
      ST_WAIT_ACK:  BUSY = 1'b1;
      ST_WAIT_IDLE: BUSY = 1'b1;
      ST_DONE:      BYTE_SENT = 1'b1;
      default: begin
        BUSY = 1'b0;
      end
    endcase
  end

  assign BYTE_ERROR_CODE = err_code;

endmodule
`default_nettype wire
